// File: rtl/config_loader_pkg.sv
// Shared types and constants for the logic-cell configuration loader.
// The CRC feature is enabled by CONFIG_LOADER_CRC_EN.
package config_pkg;

    localparam int          BITS_PER_CELL = 18;
    localparam logic [15:0] CRC_POLY      = 16'h1021;
    localparam logic [15:0] CRC_INIT      = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
`ifdef CONFIG_LOADER_CRC_EN
        ,
        ST_CHECK = 3'd5
`endif
    } state_t;

endpackage

// File: rtl/config_loader_if.sv
// Host-side bitstream word handshake for config_loader.
// Host is the master, the loader is the slave.
interface config_loader_if #(
    parameter int WORD_WIDTH = 8
) ();

    logic [WORD_WIDTH-1:0] i_Data;
    logic                  i_DataValid;
    logic                  o_DataReady;

    modport master (
        output i_Data,
        output i_DataValid,
        input  o_DataReady
    );

    modport slave (
        input  i_Data,
        input  i_DataValid,
        output o_DataReady
    );

endinterface

// File: rtl/config_loader_crc16_serial.sv
// Bit-serial CRC-16-CCITT over the shifted configuration stream.
// Only instantiated when CONFIG_LOADER_CRC_EN is defined.
module crc16_serial
    import config_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_Clear,
    input  logic        i_Enable,
    input  logic        i_Data,
    output logic [15:0] o_Crc
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;
    logic        fb;

    // Next CRC: clear wins, otherwise one LFSR step per enabled bit.
    always_comb begin
        crc_d = crc_q;
        fb    = crc_q[15] ^ i_Data;
        if (i_Clear) begin
            crc_d = CRC_INIT;
        end else if (i_Enable) begin
            crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
        end
    end

    // CRC state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign o_Crc = crc_q;

endmodule

// File: rtl/config_loader.sv
// Loads a logic-cell chain from host words, one bit per cycle, LSB first.
// CONFIG_LOADER_CRC_EN adds a CRC-16 check state before DONE.
module config_loader #(
    parameter int NUM_CELLS     = 4,
    parameter int BITS_PER_CELL = config_pkg::BITS_PER_CELL,
    parameter int WORD_WIDTH    = 8
) (
    input  logic            i_ConfigClock,
    input  logic            i_Reset_n,
    input  logic            i_Start,
    input  logic            i_Abort,
    input  logic [15:0]     i_ExpectedCrc,
    config_loader_if.slave  host,
    output logic            o_ChainShiftData,
    output logic            o_ChainClockEnable,
    output logic            o_ConfigActive,
    output logic            o_Busy,
    output logic            o_Done,
    output logic            o_Error
);

    import config_pkg::*;

    localparam int TOTAL_BITS = NUM_CELLS * BITS_PER_CELL;
    localparam int NUM_WORDS  = TOTAL_BITS / WORD_WIDTH;
    localparam int WCW        = $clog2(NUM_WORDS + 1);
    localparam int BCW        = $clog2(WORD_WIDTH + 1);

    generate
        if (TOTAL_BITS % WORD_WIDTH != 0) begin : g_bad_width
            $error("chain length is not a whole number of words");
        end
    endgenerate

    state_t                state_q, state_d;
    logic [WORD_WIDTH-1:0] word_q, word_d;
    logic [WCW-1:0]        wcnt_q, wcnt_d;
    logic [BCW-1:0]        bcnt_q, bcnt_d;
    logic                  sd_q, sd_d;
    logic                  cen_q, cen_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  cfg_q, cfg_d;
    logic                  crc_clr;

`ifdef CONFIG_LOADER_CRC_EN
    logic [15:0] exp_q, exp_d;
    logic [15:0] crc;

    crc16_serial u_crc (
        .clk      (i_ConfigClock),
        .rst_n    (i_Reset_n),
        .i_Clear  (crc_clr),
        .i_Enable (cen_q),
        .i_Data   (sd_q),
        .o_Crc    (crc)
    );
`else
    logic unused_crc;
    assign unused_crc = ^{i_ExpectedCrc, crc_clr};
`endif

    // Sequencer: next state and next registered outputs.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        wcnt_d  = wcnt_q;
        bcnt_d  = bcnt_q;
        sd_d    = 1'b0;
        cen_d   = 1'b0;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        cfg_d   = cfg_q;
        crc_clr = 1'b0;
`ifdef CONFIG_LOADER_CRC_EN
        exp_d   = exp_q;
`endif
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (i_Start) begin
                    state_d = ST_LOAD;
                    wcnt_d  = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    cfg_d   = 1'b0;
                    crc_clr = 1'b1;
`ifdef CONFIG_LOADER_CRC_EN
                    exp_d   = i_ExpectedCrc;
`endif
                end
            end
            ST_LOAD: begin
                if (i_Abort) begin
                    state_d = ST_ERROR;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end else if (host.i_DataValid) begin
                    state_d = ST_SHIFT;
                    sd_d    = host.i_Data[0];
                    cen_d   = 1'b1;
                    word_d  = host.i_Data >> 1;
                    bcnt_d  = '0;
                    wcnt_d  = wcnt_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (i_Abort) begin
                    state_d = ST_ERROR;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end else if (bcnt_q == BCW'(WORD_WIDTH - 1)) begin
                    if (wcnt_q != WCW'(NUM_WORDS)) begin
                        state_d = ST_LOAD;
                    end else begin
`ifdef CONFIG_LOADER_CRC_EN
                        state_d = ST_CHECK;
`else
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        cfg_d   = 1'b1;
`endif
                    end
                end else begin
                    sd_d   = word_q[0];
                    cen_d  = 1'b1;
                    word_d = word_q >> 1;
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
`ifdef CONFIG_LOADER_CRC_EN
            ST_CHECK: begin
                busy_d = 1'b0;
                if (crc == exp_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    cfg_d   = 1'b1;
                end else begin
                    state_d = ST_ERROR;
                    err_d   = 1'b1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset leaves cells held cleared.
    always_ff @(posedge i_ConfigClock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            wcnt_q  <= '0;
            bcnt_q  <= '0;
            sd_q    <= 1'b0;
            cen_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cfg_q   <= 1'b0;
`ifdef CONFIG_LOADER_CRC_EN
            exp_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            wcnt_q  <= wcnt_d;
            bcnt_q  <= bcnt_d;
            sd_q    <= sd_d;
            cen_q   <= cen_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cfg_q   <= cfg_d;
`ifdef CONFIG_LOADER_CRC_EN
            exp_q   <= exp_d;
`endif
        end
    end

    assign host.o_DataReady   = (state_q == ST_LOAD);
    assign o_ChainShiftData   = sd_q;
    assign o_ChainClockEnable = cen_q;
    assign o_ConfigActive     = cfg_q;
    assign o_Busy             = busy_q;
    assign o_Done             = done_q;
    assign o_Error            = err_q;

endmodule

// File: tb/tb_config_loader.sv
// Directed/randomized bench for config_loader with a stream-level model.
// Covers CONFIG_LOADER_CRC_EN when the macro is defined.
module tb_config_loader;

    import config_pkg::*;

    localparam int NC  = 4;
    localparam int BPC = 18;
    localparam int WW  = 8;
    localparam int TB  = NC * BPC;
    localparam int NW  = TB / WW;
`ifdef CONFIG_LOADER_CRC_EN
    localparam int DONE_CYC = 1 + NW * (WW + 1) + 1;
`else
    localparam int DONE_CYC = 1 + NW * (WW + 1);
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] exp_crc_in = '0;
    logic        sd, cen, cfg, busy, done, err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [WW-1:0] words [NW];
    bit            obs [$];
    logic [TB-1:0] chain;

    config_loader_if #(.WORD_WIDTH(WW)) host ();

    config_loader #(
        .NUM_CELLS     (NC),
        .BITS_PER_CELL (BPC),
        .WORD_WIDTH    (WW)
    ) dut (
        .i_ConfigClock      (clk),
        .i_Reset_n          (rst_n),
        .i_Start            (start),
        .i_Abort            (abort),
        .i_ExpectedCrc      (exp_crc_in),
        .host               (host.slave),
        .o_ChainShiftData   (sd),
        .o_ChainClockEnable (cen),
        .o_ConfigActive     (cfg),
        .o_Busy             (busy),
        .o_Done             (done),
        .o_Error            (err)
    );

    always #5 clk = ~clk;

    // Chain model: every enabled cycle pushes one bit into cell 0 bit 0.
    always @(negedge clk) begin
        if (rst_n && cen === 1'b1) begin
            obs.push_back(sd);
            chain = {chain[TB-2:0], sd};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [127:0] o,
                         input logic [127:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    function automatic bit stream_bit(input int n);
        logic [WW-1:0] w;
        w = words[n / WW];
        return w[n % WW];
    endfunction

`ifdef CONFIG_LOADER_CRC_EN
    function automatic logic [15:0] model_crc();
        logic [15:0] c;
        c = 16'hFFFF;
        for (int n = 0; n < TB; n++) begin
            if (c[15] ^ stream_bit(n)) c = (c << 1) ^ 16'h1021;
            else c = c << 1;
        end
        return c;
    endfunction
`endif

    task automatic fill_words(input bit first_a5);
        for (int i = 0; i < NW; i++) words[i] = WW'($urandom);
        if (first_a5) words[0] = 8'hA5;
    endtask

    task automatic run_load(input int stall_at,
                            input int abort_word,
                            input bit flip);
        int cyc, hs_idx, stall_left, sh_cnt, abort_cyc;
        int cfg_bad, hs_bad, stall_bad, bit_bad;
        logic [TB-1:0] exp_chain;
        obs.delete();
        chain = '0;
`ifdef CONFIG_LOADER_CRC_EN
        exp_crc_in = model_crc() ^ (flip ? 16'h0100 : 16'h0000);
`else
        exp_crc_in = 16'($urandom);
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        check("start_busy", busy, 1);
        check("start_cfg", cfg, 0);
        check("start_ready", host.o_DataReady, 1);
        hs_idx = 0;
        stall_left = 5;
        sh_cnt = 0;
        abort_cyc = -1;
        cfg_bad = 0;
        hs_bad = 0;
        stall_bad = 0;
        while (!done && !err && cyc < 400) begin
            if (cfg !== 1'b0) cfg_bad++;
            if (cen && abort_word >= 0 && hs_idx - 1 == abort_word) begin
                sh_cnt++;
                if (sh_cnt == 3) begin
                    abort = 1'b1;
                    abort_cyc = cyc;
                end
            end
            host.i_Data = (hs_idx < NW) ? words[hs_idx] : '0;
            if (host.o_DataReady && hs_idx == stall_at && stall_left > 0) begin
                host.i_DataValid = 1'b0;
                stall_left--;
                if (cen !== 1'b0) stall_bad++;
            end else begin
                host.i_DataValid = 1'b1;
            end
            if (host.o_DataReady && host.i_DataValid && !abort) begin
                if (stall_at < 0 && cyc != 1 + hs_idx * (WW + 1)) hs_bad++;
                hs_idx++;
            end
            tick();
            abort = 1'b0;
            cyc++;
        end
        host.i_DataValid = 1'b0;
        check("no_timeout", cyc < 400, 1);
        bit_bad = 0;
        foreach (obs[i]) if (obs[i] !== stream_bit(i)) bit_bad++;
        check("stream_bits", bit_bad, 0);
        if (abort_word >= 0) begin
            check("abort_err", err, 1);
            check("abort_cyc", cyc, abort_cyc + 1);
            check("abort_busy", busy, 0);
            check("abort_cfg", cfg, 0);
            check("abort_nbits", obs.size(), abort_word * WW + 3);
            repeat (20) tick();
            check("abort_no_shift", obs.size(), abort_word * WW + 3);
            check("abort_err_held", {err, cfg, done}, 3'b100);
        end else if (flip) begin
            check("crc_err", err, 1);
            check("crc_cfg", cfg, 0);
            check("crc_done", done, 0);
            check("crc_cyc", cyc, DONE_CYC);
            check("crc_nbits", obs.size(), TB);
        end else begin
            check("done", {done, err, busy, cfg}, 4'b1001);
            check("done_cyc", cyc, DONE_CYC + (stall_at >= 0 ? 5 : 0));
            check("cen_cycles", obs.size(), TB);
            check("hs_count", hs_idx, NW);
            check("hs_timing", hs_bad, 0);
            check("cfg_low_during_load", cfg_bad, 0);
            if (stall_at >= 0) begin
                check("stall_len", stall_left, 0);
                check("stall_no_cen", stall_bad, 0);
            end
            for (int c = 0; c < NC; c++)
                for (int f = 0; f < BPC; f++)
                    exp_chain[c * BPC + f] = stream_bit(TB - 1 - (c * BPC + f));
            check("chain", chain, exp_chain);
        end
    endtask

    initial begin
        logic [7:0] first8;
        host.i_Data = '0;
        host.i_DataValid = 1'b0;
        chain = '0;
        repeat (2) tick();
        check("reset_outs",
              {cen, sd, busy, done, err, cfg, host.o_DataReady}, 0);
        rst_n = 1'b1;
        tick();

        fill_words(1'b1);
        run_load(-1, -1, 1'b0);
        for (int i = 0; i < 8; i++) first8[7 - i] = obs[i];
        check("a5_bits", first8, 8'b10100101);
        check("a5_polarity", chain[TB-1], 1'b1);

        fill_words(1'b0);
        run_load(3, -1, 1'b0);

        fill_words(1'b0);
        run_load(-1, 4, 1'b0);
        fill_words(1'b0);
        run_load(-1, -1, 1'b0);

`ifdef CONFIG_LOADER_CRC_EN
        fill_words(1'b0);
        run_load(-1, -1, 1'b1);
        fill_words(1'b0);
        run_load(-1, -1, 1'b0);
`endif

        fill_words(1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        host.i_Data = words[0];
        host.i_DataValid = 1'b1;
        tick();
        host.i_DataValid = 1'b0;
        tick();
        check("pre_reset_shift", {cen, busy}, 2'b11);
        rst_n = 1'b0;
        #1;
        check("async_reset_outs",
              {cen, sd, busy, done, err, cfg, host.o_DataReady}, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        fill_words(1'b0);
        run_load(-1, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/config_loader.md
# config_loader

Sequences configuration of a chain of logic cells. Accepts a configuration bitstream from a host as words over a valid/ready handshake and serializes it, one bit per cycle, into the chain's config shift input. While loading, it holds the cells' flip-flops cleared through their config-active input, and releases them once the whole chain is written. It sits between the host/boot interface and the logic-cell array, in the config clock domain.

## Interface
Parameters:
- NUM_CELLS, 4: number of logic cells in the chain.
- BITS_PER_CELL, 18: config bits per cell (16 LUT mask, FF bypass, clock polarity). Taken from the package.
- WORD_WIDTH, 8: host word width. NUM_CELLS*BITS_PER_CELL must be a multiple of WORD_WIDTH; otherwise elaboration fails.

Ports:
- i_ConfigClock  in  1  sole clock
- i_Reset_n  in  1  reset, asynchronous assert, active-low
- i_Start  in  1  single-cycle pulse that begins a load
- i_Abort  in  1  cancels a load in progress
- i_Data  in  WORD_WIDTH  bitstream word
- i_DataValid  in  1  i_Data is valid
- o_DataReady  out  1  loader accepts a word this cycle
- i_ExpectedCrc  in  16  expected CRC, latched at i_Start
- o_ChainShiftData  out  1  drives the first cell's config shift input
- o_ChainClockEnable  out  1  enable to the top-level clock gate that produces the chain's config clock
- o_ConfigActive  out  1  drives the cells' config-active input; 0 holds all cell flip-flops cleared
- o_Busy  out  1  load in progress
- o_Done  out  1  chain fully configured
- o_Error  out  1  load aborted or CRC mismatch

## Operation
- Derived values: TOTAL_BITS = NUM_CELLS*BITS_PER_CELL; NUM_WORDS = TOTAL_BITS/WORD_WIDTH.
- States: IDLE, LOAD, SHIFT, CHECK (present only with the macro), DONE, ERROR.
- Register reset values: state IDLE; all outputs 0; word and bit counters 0; CRC 0xFFFF.
- IDLE, DONE or ERROR, on i_Start:
  - go to LOAD;
  - clear word counter, o_Done and o_Error;
  - initialise CRC to 0xFFFF; latch i_ExpectedCrc.
- i_Start in LOAD, SHIFT or CHECK is ignored.
- LOAD:
  - o_DataReady = 1.
  - On i_DataValid & o_DataReady, latch i_Data and go to SHIFT.
- SHIFT:
  - Lasts exactly WORD_WIDTH cycles.
  - In each cycle, o_ChainClockEnable = 1 and o_ChainShiftData = current bit, LSB first.
  - After the last bit: if more words remain, go to LOAD; otherwise go to CHECK (macro) or DONE.
- Bit order: the first bit of the stream ends up in the polarity bit of the last cell. The last bit ends up in LUT mask bit 0 of the first cell.
- o_ChainClockEnable is 1 only in SHIFT. The chain never shifts outside a load.
- o_ConfigActive is 1 only in DONE. Entering LOAD drops it to 0, which clears every cell flip-flop.
- o_Busy is 1 in LOAD, SHIFT and CHECK.
- i_Abort in LOAD or SHIFT: go to ERROR next cycle. Partially shifted data remains in the chain.
- i_Abort has priority over a handshake or a shift completing in the same cycle.
- ERROR: o_Error = 1 and o_ConfigActive = 0, held until the next i_Start.
- DONE: o_Done = 1, held until the next i_Start.
- Reset mid-load: immediate return to reset values. The chain contents are undefined and the cells are held cleared.

## Timing
- All outputs are registered. o_DataReady is decoded from the registered state.
- i_Start at cycle 0: LOAD and o_ConfigActive = 0 at cycle 1.
- Handshake at cycle t: SHIFT bits at cycles t+1 … t+WORD_WIDTH; LOAD again at t+WORD_WIDTH+1.
- Peak throughput: one word per WORD_WIDTH+1 cycles.
- After the last shift: DONE at the next cycle, or CHECK for one cycle and then DONE/ERROR.

## Configuration
- Macro: CONFIG_LOADER_CRC_EN.
- Defined:
  - A bit-serial CRC-16-CCITT (polynomial 0x1021, init 0xFFFF) updates on every shifted bit.
  - CHECK compares it to the latched i_ExpectedCrc: equal goes to DONE, mismatch goes to ERROR.
- Undefined:
  - No CRC logic and no CHECK state.
  - i_ExpectedCrc is ignored.
  - o_Error is set only by i_Abort.

## Structure
- Package config_pkg holds:
  - the state enum;
  - BITS_PER_CELL = 18;
  - CRC_POLY = 16'h1021 and CRC_INIT = 16'hFFFF.
- Sub-module crc16_serial: 1-bit data input, enable, clear, 16-bit state. Instantiated only under the macro.

## Test plan
- Defaults (72 bits, 9 words), i_DataValid held at 1, i_Start at cycle 0:
  - handshakes at cycles 1, 10, …, 73;
  - o_ChainClockEnable high for exactly 72 cycles;
  - DONE at cycle 82 without the macro;
  - o_ConfigActive 0 from cycle 1 until DONE.
- Word 0xA5 as the first word: o_ChainShiftData sequence 1,0,1,0,0,1,0,1. A chain model shows bit 0 of 0xA5 landing in the last cell's polarity bit.
- i_DataValid deasserted for 5 cycles mid-stream: loader stays in LOAD with o_ChainClockEnable = 0, and resumes with no lost or duplicated bits.
- i_Abort during the 3rd shift of word 4: ERROR next cycle, o_Error = 1, no further enable pulses. A subsequent i_Start completes a clean load.
- Macro defined:
  - correct i_ExpectedCrc: DONE one cycle after CHECK;
  - i_ExpectedCrc with one bit flipped: ERROR, o_ConfigActive stays 0.
- i_Reset_n low during SHIFT: all outputs 0 immediately. i_Start after release gives a normal load.
